bp_cacc_wormhole_concentrator_n: RTL and testbench
==================================================

Name: bp_cacc_wormhole_concentrator_n

Overview:
- Parametrised N-input wormhole concentrator/deconcentrator for accelerator tiles hosting several LCE/CCE endpoints behind one coherence-NoC port.
- Merge path: packets from num_in_p local channels are arbitrated onto one concentrated link. Each grant is held for the whole packet.
- Split path: packets arriving on the concentrated link are steered to a local channel by the header cid field.
- Adds selectable arbitration policy, misrouted-cid drop with a sticky error flag, and per-direction packet counters.

Parameters:
- num_in_p, 4, number of local channels (≥2).
- flit_width_p, 64, flit width in bits.
- cord_width_p, 7, header destination cord width; occupies bits [cord_width_p-1:0].
- len_width_p, 4, header length field; occupies the next len_width_p bits. Value = flits following the header.
- cid_width_p, 2, header cid field; occupies the next cid_width_p bits. Requires 2^cid_width_p ≥ num_in_p.
- rr_p, 1, arbitration policy: 1 = round-robin, 0 = fixed priority (lowest index wins).
- cnt_width_p, 16, width of each packet counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- in_data_i  in  num_in_p*flit_width_p  local channel flits; channel k occupies slice k.
- in_v_i  in  num_in_p  local channel valid.
- in_ready_and_o  out  num_in_p  local channel ready; a flit transfers when v and ready are both high.
- conc_data_o  out  flit_width_p  concentrated outbound flit.
- conc_v_o  out  1  concentrated outbound valid.
- conc_ready_and_i  in  1  concentrated outbound ready.
- conc_data_i  in  flit_width_p  concentrated inbound flit.
- conc_v_i  in  1  concentrated inbound valid.
- conc_ready_and_o  out  1  concentrated inbound ready.
- out_data_o  out  num_in_p*flit_width_p  local outbound flits; the same flit is broadcast to every slice.
- out_v_o  out  num_in_p  local outbound valid.
- out_ready_and_i  in  num_in_p  local outbound ready.
- cid_err_o  out  1  sticky flag, set on an inbound cid ≥ num_in_p.
- merge_pkts_o  out  cnt_width_p  count of merged headers transferred.
- split_pkts_o  out  cnt_width_p  count of split headers delivered; dropped packets are excluded.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - both FSMs go to IDLE; remaining counts = 0; rr pointer = 0;
  - cid_err_o = 0; both packet counters = 0;
  - all ready and valid outputs are 0 while reset is high.
- A reset asserted mid-packet abandons the packet. No partial state survives.
- Merge FSM, states IDLE and BUSY(grant g, remaining r):
  - IDLE: the arbiter picks g among asserted in_v_i.
    - rr_p=1: first asserted index at or above the pointer, wrapping at num_in_p.
    - rr_p=0: lowest asserted index.
  - Path is zero-latency, combinational: conc_v_o = in_v_i[g], conc_data_o = slice g, in_ready_and_o[g] = conc_ready_and_i. All other readies are 0.
  - On header transfer:
    - merge_pkts_o increments;
    - rr pointer becomes (g+1) mod num_in_p;
    - if len ≠ 0, go to BUSY with r = len; if len = 0, stay IDLE (single-flit packet).
  - The grant is not re-evaluated while a header is offered but not accepted. The header holds until transferred.
  - BUSY: g stays locked and other channels are ignored. Each transfer decrements r; on the transfer with r = 1, return to IDLE.
  - Back-to-back packets are allowed: IDLE arbitrates in the cycle after the last flit.
- Split FSM, states IDLE, DELIVER(d, r), DROP(r):
  - IDLE: read cid from conc_data_i.
    - cid < num_in_p: out_v_o[cid] = conc_v_i and conc_ready_and_o = out_ready_and_i[cid]. On transfer, split_pkts_o increments; go to DELIVER if len ≠ 0.
    - cid ≥ num_in_p: conc_ready_and_o = 1 and no out_v_o is raised. On transfer, set cid_err_o; go to DROP if len ≠ 0.
  - DELIVER: steer to d until r reaches 0.
  - DROP: consume r flits with ready held at 1, then return to IDLE.
  - cid_err_o clears only on reset.
- Merge and split paths are fully independent and may transfer in the same cycle.
- Counters wrap modulo 2^cnt_width_p.
- Invariant: at most one bit of out_v_o and at most one bit of in_ready_and_o is high in any cycle.

Test Plan:
- num_in_p=4, rr_p=1, all channels offer a 0-length header continuously, conc ready = 1 → grants 0,1,2,3,0 on consecutive cycles; merge_pkts_o = 5 after 5 cycles.
- Channel 1 sends a len=3 packet; channel 0 raises valid at the second flit → channel 1's 4 flits go out contiguously, channel 0 is granted the next cycle; merge_pkts_o = 2.
- rr_p=0, channels 2 and 3 both valid with len=0, repeated → channel 2 always wins while it stays valid; in_ready_and_o[3] = 0.
- Inbound header cid=2, len=2; out_ready_and_i[2] toggles 1,0,1,1 → 3 flits delivered only on out_v_o[2], stalled cycle respected; split_pkts_o = 1.
- Inbound header cid=5 (cid_width_p=3, num_in_p=4), len=1 → 2 flits consumed with conc_ready_and_o = 1, out_v_o stays 0, cid_err_o = 1 and stays 1; split_pkts_o unchanged.
- Assert reset_i asynchronously mid-packet (merge r=2) → outputs go to 0 immediately; after release, a fresh header from channel 3 is granted with pointer 0 semantics.

Source files
------------

// File: rtl/bp_cacc_wormhole_concentrator_n.sv
// Wormhole concentrator/deconcentrator.
// Merge path: num_in_p local channels share one concentrated outbound link.
// The grant is held for a whole packet.
// Split path: inbound packets are steered to a local channel by the header
// cid. Packets whose cid names no channel are dropped, and a sticky error
// flag is raised.
module bp_cacc_wormhole_concentrator_n #(
    parameter int num_in_p     = 4,
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4,
    parameter int cid_width_p  = 2,
    parameter int rr_p         = 1,
    parameter int cnt_width_p  = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p*flit_width_p-1:0] in_data_i,
    input  logic [num_in_p-1:0]              in_v_i,
    output logic [num_in_p-1:0]              in_ready_and_o,
    output logic [flit_width_p-1:0]          conc_data_o,
    output logic                             conc_v_o,
    input  logic                             conc_ready_and_i,
    input  logic [flit_width_p-1:0]          conc_data_i,
    input  logic                             conc_v_i,
    output logic                             conc_ready_and_o,
    output logic [num_in_p*flit_width_p-1:0] out_data_o,
    output logic [num_in_p-1:0]              out_v_o,
    input  logic [num_in_p-1:0]              out_ready_and_i,
    output logic                             cid_err_o,
    output logic [cnt_width_p-1:0]           merge_pkts_o,
    output logic [cnt_width_p-1:0]           split_pkts_o
);
    localparam int gw      = (num_in_p > 1) ? $clog2(num_in_p) : 1;
    localparam int len_lsb = cord_width_p;
    localparam int cid_lsb = cord_width_p + len_width_p;
    localparam logic [gw:0]          num_in_w = (gw+1)'(num_in_p);
    localparam logic [cid_width_p:0] num_in_c = (cid_width_p+1)'(num_in_p);

    typedef enum logic       {M_IDLE, M_BUSY} merge_state_e;
    typedef enum logic [1:0] {S_IDLE, S_DELIVER, S_DROP} split_state_e;

    // (a + b) mod num_in_p, for a and b already below num_in_p
    function automatic logic [gw-1:0] wrap_add(input logic [gw-1:0] a, input logic [gw-1:0] b);
        logic [gw:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= num_in_w) s = s - num_in_w;
        return s[gw-1:0];
    endfunction

    logic [flit_width_p-1:0] in_flit [num_in_p];
    for (genvar k = 0; k < num_in_p; k++) begin : g_unpack
        assign in_flit[k] = in_data_i[k*flit_width_p +: flit_width_p];
    end

    // ---------------- merge path ----------------
    merge_state_e            m_state_q;
    logic [gw-1:0]           g_q, ptr_q;
    logic                    hold_q;       // header offered but not yet taken
    logic [len_width_p-1:0]  m_rem_q;
    logic [cnt_width_p-1:0]  merge_cnt_q;

    logic [gw-1:0]           arb_g, cand, grant;
    logic                    arb_v, grant_v, merge_xfer;
    logic [len_width_p-1:0]  merge_len;

    // Arbiter: scan from lowest priority to highest so the last hit wins.
    // NOTE: always_comb gives every output a default first, so no path can leave a latch.
    always_comb begin
        arb_g = '0;
        arb_v = 1'b0;
        cand  = '0;
        for (int k = num_in_p - 1; k >= 0; k--) begin
            cand = (rr_p != 0) ? wrap_add(ptr_q, k[gw-1:0]) : k[gw-1:0];
            if (in_v_i[cand]) begin
                arb_g = cand;
                arb_v = 1'b1;
            end
        end
    end

    // A locked grant (mid-packet, or header waiting) overrides the arbiter.
    always_comb begin
        if (m_state_q == M_BUSY || hold_q) begin
            grant   = g_q;
            grant_v = 1'b1;
        end else begin
            grant   = arb_g;
            grant_v = arb_v;
        end
    end

    assign conc_data_o = in_flit[grant];
    // NOTE: state registers reset asynchronously, but the combinational handshake outputs are gated by reset_i.
    assign conc_v_o    = ~reset_i & grant_v & in_v_i[grant];
    assign merge_xfer  = conc_v_o & conc_ready_and_i;
    assign merge_len   = conc_data_o[len_lsb +: len_width_p];

    // Only the granted channel sees the concentrated ready.
    always_comb begin
        in_ready_and_o = '0;
        if (!reset_i && grant_v) in_ready_and_o[grant] = conc_ready_and_i;
    end

    // Merge FSM: grant lock, remaining-flit count, rr pointer, header counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_state_q   <= M_IDLE;
            g_q         <= '0;
            ptr_q       <= '0;
            hold_q      <= 1'b0;
            m_rem_q     <= '0;
            merge_cnt_q <= '0;
        end else begin
            case (m_state_q)
                M_IDLE: begin
                    if (merge_xfer) begin
                        merge_cnt_q <= merge_cnt_q + cnt_width_p'(1);
                        ptr_q       <= wrap_add(grant, gw'(1));
                        hold_q      <= 1'b0;
                        if (merge_len != '0) begin
                            m_state_q <= M_BUSY;
                            g_q       <= grant;
                            m_rem_q   <= merge_len;
                        end
                    end else if (conc_v_o) begin
                        hold_q <= 1'b1;
                        g_q    <= grant;
                    end else begin
                        hold_q <= 1'b0;
                    end
                end
                M_BUSY: begin
                    if (merge_xfer) begin
                        m_rem_q <= m_rem_q - len_width_p'(1);
                        if (m_rem_q == len_width_p'(1)) m_state_q <= M_IDLE;
                    end
                end
                default: m_state_q <= M_IDLE;
            endcase
        end
    end

    // ---------------- split path ----------------
    split_state_e            s_state_q;
    logic [gw-1:0]           d_q;
    logic [len_width_p-1:0]  s_rem_q;
    logic                    err_q;
    logic [cnt_width_p-1:0]  split_cnt_q;

    logic [cid_width_p-1:0]  s_cid;
    logic [len_width_p-1:0]  s_len;
    logic [gw-1:0]           s_dst;
    logic                    cid_ok, s_deliver, split_xfer;

    assign s_cid     = conc_data_i[cid_lsb +: cid_width_p];
    assign s_len     = conc_data_i[len_lsb +: len_width_p];
    assign cid_ok    = ({1'b0, s_cid} < num_in_c);
    assign s_deliver = (s_state_q == S_DELIVER) || (s_state_q == S_IDLE && cid_ok);
    assign s_dst     = (s_state_q == S_DELIVER) ? d_q : s_cid[gw-1:0];

    assign out_data_o       = {num_in_p{conc_data_i}};
    assign conc_ready_and_o = reset_i ? 1'b0 : (s_deliver ? out_ready_and_i[s_dst] : 1'b1);
    assign split_xfer       = conc_v_i & conc_ready_and_o;

    // Steer inbound valid to the single destination channel.
    always_comb begin
        out_v_o = '0;
        if (!reset_i && s_deliver) out_v_o[s_dst] = conc_v_i;
    end

    // Split FSM: destination lock, drop mode, error flag, header counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s_state_q   <= S_IDLE;
            d_q         <= '0;
            s_rem_q     <= '0;
            err_q       <= 1'b0;
            split_cnt_q <= '0;
        end else begin
            case (s_state_q)
                S_IDLE: begin
                    if (split_xfer) begin
                        if (cid_ok) begin
                            split_cnt_q <= split_cnt_q + cnt_width_p'(1);
                            if (s_len != '0) begin
                                s_state_q <= S_DELIVER;
                                d_q       <= s_cid[gw-1:0];
                                s_rem_q   <= s_len;
                            end
                        end else begin
                            err_q <= 1'b1;
                            if (s_len != '0) begin
                                s_state_q <= S_DROP;
                                s_rem_q   <= s_len;
                            end
                        end
                    end
                end
                S_DELIVER, S_DROP: begin
                    if (split_xfer) begin
                        s_rem_q <= s_rem_q - len_width_p'(1);
                        if (s_rem_q == len_width_p'(1)) s_state_q <= S_IDLE;
                    end
                end
                default: s_state_q <= S_IDLE;
            endcase
        end
    end

    assign cid_err_o    = err_q;
    assign merge_pkts_o = merge_cnt_q;
    assign split_pkts_o = split_cnt_q;
endmodule

// File: tb/tb_bp_cacc_wormhole_concentrator_n.sv
// Bench for bp_cacc_wormhole_concentrator_n: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// packet-level reference model.
module tb_bp_cacc_wormhole_concentrator_n;
    localparam int N  = 4;
    localparam int FW = 64;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b0;
    logic [N*FW-1:0] in_data_i = '0;
    logic [N-1:0]    in_v_i = '0;
    logic [N-1:0]    in_ready_and_o;
    logic [FW-1:0]   conc_data_o;
    logic            conc_v_o;
    logic            conc_ready_and_i = 1'b0;
    logic [FW-1:0]   conc_data_i = '0;
    logic            conc_v_i = 1'b0;
    logic            conc_ready_and_o;
    logic [N*FW-1:0] out_data_o;
    logic [N-1:0]    out_v_o;
    logic [N-1:0]    out_ready_and_i = '0;
    logic            cid_err_o;
    logic [15:0]     merge_pkts_o, split_pkts_o;

    // fixed-priority instance, merge side only
    logic [N*FW-1:0] fp_in_data = '0;
    logic [N-1:0]    fp_in_v = '0;
    logic [N-1:0]    fp_in_ready;
    logic [FW-1:0]   fp_conc_data;
    logic            fp_conc_v;
    logic            fp_conc_ready = 1'b0;
    logic            fp_conc_ready_o;
    logic [N*FW-1:0] fp_out_data;
    logic [N-1:0]    fp_out_v;
    logic            fp_err;
    logic [15:0]     fp_merge_pkts, fp_split_pkts;

    int n_tests = 0;
    int n_fail  = 0;

    bp_cacc_wormhole_concentrator_n #(.num_in_p(N), .flit_width_p(FW), .cord_width_p(7),
        .len_width_p(4), .cid_width_p(3), .rr_p(1), .cnt_width_p(16)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_data_i(in_data_i), .in_v_i(in_v_i), .in_ready_and_o(in_ready_and_o),
        .conc_data_o(conc_data_o), .conc_v_o(conc_v_o), .conc_ready_and_i(conc_ready_and_i),
        .conc_data_i(conc_data_i), .conc_v_i(conc_v_i), .conc_ready_and_o(conc_ready_and_o),
        .out_data_o(out_data_o), .out_v_o(out_v_o), .out_ready_and_i(out_ready_and_i),
        .cid_err_o(cid_err_o), .merge_pkts_o(merge_pkts_o), .split_pkts_o(split_pkts_o));

    bp_cacc_wormhole_concentrator_n #(.num_in_p(N), .flit_width_p(FW), .cord_width_p(7),
        .len_width_p(4), .cid_width_p(3), .rr_p(0), .cnt_width_p(16)) u_fp (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_data_i(fp_in_data), .in_v_i(fp_in_v), .in_ready_and_o(fp_in_ready),
        .conc_data_o(fp_conc_data), .conc_v_o(fp_conc_v), .conc_ready_and_i(fp_conc_ready),
        .conc_data_i('0), .conc_v_i(1'b0), .conc_ready_and_o(fp_conc_ready_o),
        .out_data_o(fp_out_data), .out_v_o(fp_out_v), .out_ready_and_i('0),
        .cid_err_o(fp_err), .merge_pkts_o(fp_merge_pkts), .split_pkts_o(fp_split_pkts));

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [N*FW-1:0] act, input logic [N*FW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Header flit: random cord/payload with the len and cid fields set.
    function automatic logic [FW-1:0] hdr(input int cid, input int len);
        logic [FW-1:0] f;
        f = {$urandom, $urandom};
        f[10:7]  = len[3:0];
        f[13:11] = cid[2:0];
        return f;
    endfunction

    // ---------------- reference model (rr_p = 1 instance) ----------------
    int          m_owner = -1;  // channel owning the link mid-packet
    int          m_rem   = 0;
    int          m_ptr   = 0;
    int          m_hold  = -1;  // channel whose header is waiting
    int          s_mode  = 0;   // 0 idle, 1 deliver, 2 drop
    int          s_dst   = 0;
    int          s_rem   = 0;
    logic        m_err   = 1'b0;
    logic [15:0] m_mcnt  = '0;
    logic [15:0] m_scnt  = '0;

    task automatic model_step();
        int g, cid, len;
        logic [N-1:0] e_rdy, e_ov;
        logic e_cv, e_cr;
        if (reset_i) begin
            check("rst_in_ready", in_ready_and_o, '0);
            check("rst_conc_v", conc_v_o, '0);
            check("rst_out_v", out_v_o, '0);
            check("rst_conc_ready", conc_ready_and_o, '0);
            check("rst_cid_err", cid_err_o, '0);
            check("rst_merge_cnt", merge_pkts_o, '0);
            check("rst_split_cnt", split_pkts_o, '0);
            m_owner = -1; m_rem = 0; m_ptr = 0; m_hold = -1;
            s_mode = 0; s_dst = 0; s_rem = 0; m_err = 1'b0; m_mcnt = '0; m_scnt = '0;
            return;
        end
        // merge: who owns the link this cycle
        g = -1;
        if (m_owner >= 0) g = m_owner;
        else if (m_hold >= 0) g = m_hold;
        else begin
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (g < 0 && in_v_i[c]) g = c;
            end
        end
        e_cv  = (g >= 0) && in_v_i[g];
        e_rdy = (g >= 0 && conc_ready_and_i) ? (4'b0001 << g) : 4'b0000;
        check("merge_v", conc_v_o, e_cv);
        check("merge_ready", in_ready_and_o, e_rdy);
        if (e_cv) check("merge_data", conc_data_o, in_data_i[g*FW +: FW]);
        // split: where the inbound flit goes
        cid = int'(conc_data_i[13:11]);
        len = int'(conc_data_i[10:7]);
        if (s_mode == 1) begin
            e_ov = conc_v_i ? (4'b0001 << s_dst) : 4'b0000; e_cr = out_ready_and_i[s_dst];
        end else if (s_mode == 2 || cid >= N) begin
            e_ov = '0; e_cr = 1'b1;
        end else begin
            e_ov = conc_v_i ? (4'b0001 << cid) : 4'b0000; e_cr = out_ready_and_i[cid];
        end
        check("split_v", out_v_o, e_ov);
        check("split_ready", conc_ready_and_o, e_cr);
        if (e_ov != '0) check("split_data", out_data_o, {N{conc_data_i}});
        check("cid_err", cid_err_o, m_err);
        check("merge_cnt", merge_pkts_o, m_mcnt);
        check("split_cnt", split_pkts_o, m_scnt);
        check("onehot_in_ready", $onehot0(in_ready_and_o), 1'b1);
        check("onehot_out_v", $onehot0(out_v_o), 1'b1);
        // advance merge model
        if (e_cv && conc_ready_and_i) begin
            if (m_owner < 0) begin
                m_mcnt++;
                m_ptr  = (g + 1) % N;
                m_hold = -1;
                len = int'(in_data_i[g*FW+7 +: 4]);
                if (len > 0) begin m_owner = g; m_rem = len; end
            end else begin
                m_rem--;
                if (m_rem == 0) m_owner = -1;
            end
        end else if (m_owner < 0) begin
            m_hold = e_cv ? g : -1;
        end
        // advance split model
        len = int'(conc_data_i[10:7]);
        if (conc_v_i && e_cr) begin
            if (s_mode == 0) begin
                if (cid < N) begin
                    m_scnt++;
                    if (len > 0) begin s_mode = 1; s_dst = cid; s_rem = len; end
                end else begin
                    m_err = 1'b1;
                    if (len > 0) begin s_mode = 2; s_rem = len; end
                end
            end else begin
                s_rem--;
                if (s_rem == 0) s_mode = 0;
            end
        end
    endtask

    // compare process: every cycle, away from the rising edge
    always begin
        @(negedge clk_i);
        #2;
        model_step();
    end

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        in_v_i = '0; conc_v_i = 1'b0; fp_in_v = '0;
        out_ready_and_i = '0; conc_ready_and_i = 1'b0; fp_conc_ready = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    logic [FW-1:0] f0, f1, f2, f3;
    logic [N-1:0]  acc;
    logic          s_acc;
    int            left[N];
    bit            pend[N];
    int            s_left;
    bit            s_pend;

    initial begin
        #1 reset_i = 1'b1;
        #20;
        do_reset();

        // 1: all channels offer single-flit packets -> grants rotate 0,1,2,3,0
        @(negedge clk_i);
        conc_ready_and_i = 1'b1;
        for (int k = 0; k < N; k++) in_data_i[k*FW +: FW] = hdr(0, 0);
        in_v_i = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #2 check("t1_grant", in_ready_and_o, 4'b0001 << (c % 4));
            @(negedge clk_i);
        end
        #2 check("t1_count", merge_pkts_o, 16'd5);
        @(negedge clk_i);
        in_v_i = '0;

        // 2: channel 1 len=3 packet is not interrupted by channel 0
        do_reset();
        f0 = hdr(0, 3); f1 = {$urandom, $urandom}; f2 = {$urandom, $urandom}; f3 = {$urandom, $urandom};
        @(negedge clk_i);
        conc_ready_and_i = 1'b1;
        in_data_i[1*FW +: FW] = f0; in_v_i[1] = 1'b1;
        #2 check("t2_hdr_grant", in_ready_and_o, 4'b0010);
        check("t2_hdr_data", conc_data_o, f0);
        @(negedge clk_i);
        in_data_i[1*FW +: FW] = f1;
        in_data_i[0*FW +: FW] = hdr(1, 0); in_v_i[0] = 1'b1;
        #2 check("t2_body1_grant", in_ready_and_o, 4'b0010);
        check("t2_body1_data", conc_data_o, f1);
        @(negedge clk_i);
        in_data_i[1*FW +: FW] = f2;
        #2 check("t2_body2_grant", in_ready_and_o, 4'b0010);
        @(negedge clk_i);
        in_data_i[1*FW +: FW] = f3;
        #2 check("t2_body3_grant", in_ready_and_o, 4'b0010);
        check("t2_body3_data", conc_data_o, f3);
        @(negedge clk_i);
        in_v_i[1] = 1'b0;
        #2 check("t2_ch0_grant", in_ready_and_o, 4'b0001);
        @(negedge clk_i);
        in_v_i[0] = 1'b0;
        #2 check("t2_count", merge_pkts_o, 16'd2);

        // 3: fixed priority, channels 2 and 3 contend -> 2 always wins
        @(negedge clk_i);
        fp_conc_ready = 1'b1;
        fp_in_data[2*FW +: FW] = hdr(0, 0);
        fp_in_data[3*FW +: FW] = hdr(0, 0);
        fp_in_v = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            #2 check("t3_fp_grant", fp_in_ready, 4'b0100);
            check("t3_fp_data", fp_conc_data, fp_in_data[2*FW +: FW]);
            @(negedge clk_i);
        end
        fp_in_v = '0;
        #2 check("t3_fp_count", fp_merge_pkts, 16'd4);

        // 4: inbound cid=2 len=2 with a stall on the destination
        do_reset();
        f0 = hdr(2, 2); f1 = {$urandom, $urandom}; f2 = {$urandom, $urandom};
        @(negedge clk_i);
        conc_v_i = 1'b1; conc_data_i = f0; out_ready_and_i = 4'b1111;
        #2 check("t4_hdr_v", out_v_o, 4'b0100);
        check("t4_hdr_ready", conc_ready_and_o, 1'b1);
        @(negedge clk_i);
        conc_data_i = f1; out_ready_and_i = 4'b1011;
        #2 check("t4_stall_v", out_v_o, 4'b0100);
        check("t4_stall_ready", conc_ready_and_o, 1'b0);
        @(negedge clk_i);
        out_ready_and_i = 4'b1111;
        #2 check("t4_b1_ready", conc_ready_and_o, 1'b1);
        check("t4_b1_data", out_data_o[2*FW +: FW], f1);
        @(negedge clk_i);
        conc_data_i = f2;
        #2 check("t4_b2_v", out_v_o, 4'b0100);
        check("t4_b2_ready", conc_ready_and_o, 1'b1);
        @(negedge clk_i);
        conc_v_i = 1'b0;
        #2 check("t4_count", split_pkts_o, 16'd1);

        // 5: misrouted cid=5 len=1 is consumed and flagged
        @(negedge clk_i);
        conc_v_i = 1'b1; conc_data_i = hdr(5, 1); out_ready_and_i = '0;
        #2 check("t5_hdr_v", out_v_o, 4'b0000);
        check("t5_hdr_ready", conc_ready_and_o, 1'b1);
        @(negedge clk_i);
        conc_data_i = {$urandom, $urandom};
        #2 check("t5_body_v", out_v_o, 4'b0000);
        check("t5_body_ready", conc_ready_and_o, 1'b1);
        @(negedge clk_i);
        conc_v_i = 1'b0;
        #2 check("t5_err", cid_err_o, 1'b1);
        check("t5_count", split_pkts_o, 16'd1);
        repeat (3) @(negedge clk_i);
        #2 check("t5_err_sticky", cid_err_o, 1'b1);

        // 6: asynchronous reset mid-packet, then a fresh header from channel 3
        do_reset();
        @(negedge clk_i);
        conc_ready_and_i = 1'b1;
        in_data_i[1*FW +: FW] = hdr(0, 3); in_v_i[1] = 1'b1;
        @(negedge clk_i);
        in_data_i[1*FW +: FW] = {$urandom, $urandom};
        @(negedge clk_i);
        in_data_i[1*FW +: FW] = {$urandom, $urandom};
        conc_v_i = 1'b1; conc_data_i = hdr(0, 0); out_ready_and_i = 4'b1111;
        #1 reset_i = 1'b1;
        #1 check("t6_rst_conc_v", conc_v_o, 1'b0);
        check("t6_rst_in_ready", in_ready_and_o, 4'b0000);
        check("t6_rst_out_v", out_v_o, 4'b0000);
        check("t6_rst_merge_cnt", merge_pkts_o, 16'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        in_v_i = 4'b1000; in_data_i[3*FW +: FW] = hdr(0, 0); conc_v_i = 1'b0;
        #2 check("t6_ch3_grant", in_ready_and_o, 4'b1000);
        check("t6_ch3_v", conc_v_o, 1'b1);
        @(negedge clk_i);
        in_v_i = '0;
        #2 check("t6_count", merge_pkts_o, 16'd1);

        // randomized traffic on both paths
        do_reset();
        acc = '0; s_acc = 1'b0; s_pend = 1'b0; s_left = 0;
        for (int k = 0; k < N; k++) begin pend[k] = 1'b0; left[k] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    in_v_i[k] = 1'b0;
                    if (left[k] > 0) begin
                        left[k]--;
                        in_data_i[k*FW +: FW] = {$urandom, $urandom};
                    end else pend[k] = 1'b0;
                end
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    left[k] = int'($urandom_range(0, 3));
                    in_data_i[k*FW +: FW] = hdr(int'($urandom_range(0, 7)), left[k]);
                end
                if (pend[k] && !in_v_i[k]) in_v_i[k] = ($urandom_range(0, 3) != 0);
            end
            if (s_acc) begin
                conc_v_i = 1'b0;
                if (s_left > 0) begin
                    s_left--;
                    conc_data_i = {$urandom, $urandom};
                end else s_pend = 1'b0;
            end
            if (!s_pend && $urandom_range(0, 1) == 0) begin
                s_pend = 1'b1;
                s_left = int'($urandom_range(0, 3));
                conc_data_i = hdr(int'($urandom_range(0, 7)), s_left);
            end
            if (s_pend && !conc_v_i) conc_v_i = ($urandom_range(0, 3) != 0);
            conc_ready_and_i = ($urandom_range(0, 3) != 0);
            out_ready_and_i  = 4'($urandom);
            #2;
            acc   = in_v_i & in_ready_and_o;
            s_acc = conc_v_i & conc_ready_and_o;
        end

        @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
